uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped serial output stage for the RISC-V CPU's I/O space. Accepts byte writes over the same single-cycle `write_data`/`write_enable` store interface that drives the parallel 8-bit output port. Buffers the bytes in a 4-entry FIFO and serializes them as 8N1 UART frames on one `tx` line. Status outputs can be read back by software through the I/O read mux.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit, legal range 2..65535.
- `clk`  input  1  system clock; every register updates on the posedge.
- `rst`  input  1  reset, synchronous, active-low; sampled on the posedge of `clk`.
- `write_data`  input  8  byte to transmit.
- `write_enable`  input  1  one-cycle store strobe; pushes `write_data` when sampled high.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high while the FIFO is non-empty or a frame is in flight.
- `full`  output  1  FIFO holds 4 entries.
- `fifo_count`  output  3  number of queued bytes, 0..4; excludes the byte being shifted.
- `overflow`  output  1  sticky flag; set when a write is dropped.

## Operation
- Reset (`rst` low at a posedge):
  - `tx`=1, `busy`=0, `full`=0, `fifo_count`=0, `overflow`=0.
  - State goes to IDLE and the FIFO pointers clear.
  - Reset applied mid-frame aborts the frame immediately: `tx` returns high on the next cycle and queued bytes are discarded.
- FIFO:
  - 4 × 8-bit circular buffer with 2-bit read/write pointers that wrap from 3 to 0.
  - Push: `write_enable` && !`full`.
  - Pop: only by the state machine in IDLE.
  - `full` is evaluated on the pre-edge count. A write while `full` is dropped even if a pop occurs in the same cycle, and `overflow` is set.
  - A push and a pop in the same cycle (count <4) leave `fifo_count` unchanged.
- State machine, with a baud counter of width ceil(log2(CLKS_PER_BIT)) and a 3-bit bit index:
  - IDLE: `tx`=1. If `fifo_count`≠0, pop the head into the shift register, clear the baud counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP. Bits go out LSB first.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `tx` is a registered output, glitch-free.
- `busy` = (state≠IDLE) || (`fifo_count`≠0).

## Timing
- Write sampled at edge N: `fifo_count` updates after N. IDLE pops at edge N+1. `tx` falls after edge N+1, i.e. 2 cycles after the write.
- Frame length is exactly 10×CLKS_PER_BIT cycles of non-idle `tx`: START low, then 8 data bits, then STOP high.
- Back-to-back bytes: the line spends one cycle in IDLE between the end of STOP and the next START. The total high time between frames is CLKS_PER_BIT+1 cycles.
- `full`, `fifo_count` and `overflow` are registered and reflect pushes/pops one cycle after the edge.
- `overflow` clears only on reset.
- `busy` falls in the cycle after STOP completes, provided the FIFO is empty.

## Test plan
- Reset check: hold `rst`=0 for 2 cycles → `tx`=1, `busy`=0, `full`=0, `fifo_count`=0, `overflow`=0.
- Single byte, CLKS_PER_BIT=4, write 0xA5:
  - `tx` falls 2 cycles after the write and stays low 4 cycles.
  - Data bits follow LSB first (1,0,1,0,0,1,0,1), each 4 cycles, then the stop bit high for 4 cycles.
  - `busy` drops after 40 frame cycles.
- Back-to-back: write 0x00 and 0xFF on consecutive cycles → two complete frames separated by exactly 5 high cycles. `fifo_count` goes 1, 1 (push and pop in the same cycle), then 0.
- Overflow:
  - Write 6 bytes 0x01..0x06 on consecutive cycles.
  - Byte 0x01 is popped before 0x06 arrives; `full`=1 after the fifth write.
  - 0x06 is dropped and `overflow`=1.
  - The serial output carries 0x01..0x05 only.
- Mid-frame reset: assert `rst`=0 during DATA bit 3 of 0x3C with 2 bytes queued → `tx`=1 the next cycle and `fifo_count`=0. After release, no frame is emitted without a new write.
- Wrap-around: 10 sequential single writes 0x10..0x19, each issued when `busy`=0 → ten correct frames. Pointers wrap past entry 3 without corruption.

Source files
------------

// File: rtl/uart_tx_port.sv
// uart_tx_port: 4-deep byte FIFO feeding an 8N1 UART transmitter
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] write_data,
  input  logic       write_enable,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic [2:0] fifo_count,
  output logic       overflow
);
  localparam int CW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [7:0]    mem_q [4];
  logic [1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, bit_done;
  assign push     = write_enable && (count_q != 3'd4);
  assign pop      = (state_q == IDLE) && (count_q != 3'd0);
  assign bit_done = baud_q == BAUD_LAST;
  // FIFO pointers, occupancy and sticky drop flag; full uses the pre-edge count
  always_comb begin
    wp_d    = push ? wp_q + 2'd1 : wp_q;
    rp_d    = pop ? rp_q + 2'd1 : rp_q;
    count_d = count_q + {2'b0, push} - {2'b0, pop};
    ovf_d   = ovf_q || (write_enable && count_q == 3'd4);
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= write_data;
  end
  // frame sequencer; tx is precomputed from the next state so the line is registered
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    baud_d  = (state_q == IDLE || bit_done) ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rp_q];
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          state_d = idx_q == 3'd7 ? STOP : DATA;
        end
      end
      STOP: state_d = bit_done ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  // state and FIFO registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      wp_q    <= 2'd0;
      rp_q    <= 2'd0;
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != 3'd0);
  assign full       = count_q == 3'd4;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed vector bench for uart_tx_port with CLKS_PER_BIT=4
module tb_uart_tx_port;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] write_data = 8'd0;
  logic       write_enable = 1'b0;
  logic       tx, busy, full, overflow;
  logic [2:0] fifo_count;
  int checks = 0;
  int errors = 0;

  uart_tx_port #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .write_data(write_data), .write_enable(write_enable),
    .tx(tx), .busy(busy), .full(full), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
  } fvec_t;

  typedef struct {
    logic [7:0] data;
    logic [2:0] cnt;
    logic       full;
    logic       ovf;
  } ovec_t;

  fvec_t fv[5];
  ovec_t ov[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // bits[i] is the i-th transmitted bit: start, d0..d7, stop; each lasts 4 cycles
  task automatic expect_frame(input logic [9:0] bits, input int k0, output int waited);
    waited = 0;
    if (k0 == 0)
      while (tx !== 1'b0 && waited < 200) begin
        tick();
        waited++;
      end
    for (int k = k0; k < 40; k++) begin
      chk("tx_bit", tx, bits[k/4]);
      chk("busy_in_frame", busy, 1);
      tick();
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    write_enable = 1'b1;
    write_data = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic watch_idle(input int n, input string name);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
      tick();
    end
    chk(name, lows, 0);
  endtask

  initial begin
    int w;
    fv[0] = '{8'hA5, 10'b1101001010};
    fv[1] = '{8'h5A, 10'b1010110100};
    fv[2] = '{8'h01, 10'b1000000010};
    fv[3] = '{8'h80, 10'b1100000000};
    fv[4] = '{8'hFF, 10'b1111111110};
    ov[0] = '{8'h01, 3'd1, 1'b0, 1'b0};
    ov[1] = '{8'h02, 3'd1, 1'b0, 1'b0};
    ov[2] = '{8'h03, 3'd2, 1'b0, 1'b0};
    ov[3] = '{8'h04, 3'd3, 1'b0, 1'b0};
    ov[4] = '{8'h05, 3'd4, 1'b1, 1'b0};
    ov[5] = '{8'h06, 3'd4, 1'b1, 1'b1};

    tick();
    tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      write_byte(fv[i].data);
      chk("single_count", fifo_count, 1);
      chk("single_busy", busy, 1);
      chk("single_tx_idle", tx, 1);
      expect_frame(fv[i].bits, 0, w);
      chk("start_latency", w, 1);
      chk("busy_drop", busy, 0);
      chk("tx_after_frame", tx, 1);
    end

    write_enable = 1'b1;
    write_data = 8'h00;
    tick();
    chk("b2b_count0", fifo_count, 1);
    chk("b2b_tx0", tx, 1);
    write_data = 8'hFF;
    tick();
    write_enable = 1'b0;
    chk("b2b_count1", fifo_count, 1);
    chk("b2b_tx_start", tx, 0);
    expect_frame(10'b1000000000, 0, w);
    chk("b2b_count_between", fifo_count, 1);
    expect_frame(10'b1111111110, 0, w);
    chk("b2b_high_gap", 4 + w, 5);
    chk("b2b_count_end", fifo_count, 0);
    chk("b2b_busy_end", busy, 0);

    for (int i = 0; i < 6; i++) begin
      write_enable = 1'b1;
      write_data = ov[i].data;
      tick();
      chk("ovf_count", fifo_count, ov[i].cnt);
      chk("ovf_full", full, ov[i].full);
      chk("ovf_flag", overflow, ov[i].ovf);
    end
    write_enable = 1'b0;
    expect_frame(10'b1000000010, 4, w);
    for (int i = 2; i <= 5; i++) begin
      expect_frame({1'b1, 8'(i), 1'b0}, 0, w);
      chk("ovf_gap", w, 1);
    end
    watch_idle(60, "ovf_no_sixth_frame");
    chk("ovf_sticky", overflow, 1);

    write_enable = 1'b1;
    write_data = 8'h3C;
    tick();
    write_data = 8'h11;
    tick();
    write_data = 8'h22;
    tick();
    write_enable = 1'b0;
    chk("mid_count", fifo_count, 2);
    chk("mid_tx_data0", tx, 0);
    for (int i = 0; i < 16; i++) tick();
    chk("mid_tx_bit3", tx, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overflow", overflow, 0);
    rst = 1'b1;
    watch_idle(50, "mid_no_frame");

    for (int i = 0; i < 10; i++) begin
      w = 0;
      while (busy !== 1'b0 && w < 100) begin
        tick();
        w++;
      end
      chk("wrap_idle", busy, 0);
      write_byte(8'h10 + 8'(i));
      expect_frame({1'b1, 8'h10 + 8'(i), 1'b0}, 0, w);
      chk("wrap_latency", w, 1);
    end
    chk("wrap_end_count", fifo_count, 0);
    chk("wrap_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
